// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for the cache: fetches an aligned block on a miss from a
// fixed-latency pipelined memory and forwards qualified write-throughs.
//
//  state | meaning
//  IDLE  | accept a miss (priority) or forward a write one cycle later
//  ISSUE | one read strobe per cycle, BLK_WORDS reads in address order
//  DRAIN | wait for all read data to come back
//  DONE  | QUIET cycles where miss_req is ignored, then back to IDLE
module cache_mem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BLK_WORDS  = 8,
    parameter int MEM_LAT    = 4,
    parameter int QUIET      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic                  wr_req,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int IDX_W = $clog2(BLK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int Q_W   = $clog2(QUIET + 1);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(2 * BLK_WORDS - 1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(BLK_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base;
    logic [CNT_W-1:0]        iss_cnt;
    logic [CNT_W-1:0]        ret_cnt;
    logic [Q_W-1:0]          quiet_cnt;
    // Tag pipe: {read_valid, byte_addr}; the head lines up with mem_rdata.
    logic [ADDR_WIDTH:0]     pipe [MEM_LAT];

    logic wr_qual;
    assign wr_qual = wr_valid & wr_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            base       <= '0;
            iss_cnt    <= '0;
            ret_cnt    <= '0;
            quiet_cnt  <= '0;
            rsp_addr   <= '0;
            rsp_data   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            data_valid <= 1'b0;

            // Tag taken from the strobe currently on the memory bus.
            pipe[0] <= {mem_en & ~mem_we, mem_addr};
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];

            if (pipe[MEM_LAT-1][ADDR_WIDTH]) begin
                data_valid <= 1'b1;
                rsp_addr   <= pipe[MEM_LAT-1][ADDR_WIDTH-1:0];
                rsp_data   <= mem_rdata;
                ret_cnt    <= ret_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (miss_req) begin
                        base     <= req_addr & BLK_MASK;
                        mem_en   <= 1'b1;
                        mem_addr <= req_addr & BLK_MASK;
                        iss_cnt  <= CNT_W'(1);
                        ret_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                        if (wr_qual) err <= 1'b1;
                    end else if (wr_qual) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= req_addr & WORD_MASK;
                        mem_wdata <= wr_data;
                    end
                end
                ISSUE: begin
                    if (wr_qual) err <= 1'b1;
                    if (iss_cnt == CNT_FULL) begin
                        state <= DRAIN;
                    end else begin
                        mem_en   <= 1'b1;
                        mem_addr <= base | ADDR_WIDTH'({iss_cnt[IDX_W-1:0], 1'b0});
                        iss_cnt  <= iss_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (wr_qual) err <= 1'b1;
                    if (ret_cnt == CNT_FULL) begin
                        quiet_cnt <= Q_W'(QUIET - 1);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (wr_qual) err <= 1'b1;
                    if (quiet_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        quiet_cnt <= quiet_cnt - Q_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
